i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C slave with a 7-bit address. It handles write bytes (o_rx_valid), read bytes
// (o_tx_req/i_tx_data), repeated START and STOP. It never drives SCL. SDA is open-drain:
// the block only pulls it low or leaves it released.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  inout  wire        io_scl,
  inout  wire        io_sda,
  input  logic [7:0] i_tx_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_rw,
  output logic       o_busy,
  output logic       o_stop
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
  } state_t;

  // Synchronizer chain: meta -> sync -> prev (prev is the one-cycle delayed copy)
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_meta_d, scl_sync_d, scl_prev_d;
  logic sda_meta_d, sda_sync_d, sda_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shreg_q, shreg_d;     // previously sampled bits; the 8th bit comes straight off the bus
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       done_q, done_d;       // byte finished (or master ACK seen), act on next SCL fall
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       stop_q, stop_d;

  logic scl_rise, scl_fall, scl_high, start_cond, stop_cond;

  assign io_sda = sda_oe_q ? 1'b0 : 1'bz;

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_req   = tx_req_q;
  assign o_rw       = rw_q;
  assign o_busy     = busy_q;
  assign o_stop     = stop_q;

  // Bus conditions. START and STOP need SCL stable high across both samples, so an SCL
  // edge in the same sample wins and no condition is flagged.
  always_comb begin
    scl_rise   = scl_sync_q & ~scl_prev_q;
    scl_fall   = ~scl_sync_q & scl_prev_q;
    scl_high   = scl_sync_q & scl_prev_q;
    start_cond = scl_high & ~sda_sync_q & sda_prev_q;
    stop_cond  = scl_high & sda_sync_q & ~sda_prev_q;
  end

  // Next-state logic for the synchronizers, the protocol FSM and the registered outputs
  always_comb begin
    scl_meta_d = io_scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = io_sda;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_byte_d  = tx_byte_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    stop_d     = 1'b0;

    if (stop_cond) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
      done_d   = 1'b0;
    end else if (start_cond) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[5:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (shreg_q == SLAVE_ADDR) begin
                rw_d   = sda_sync_q;
                done_d = 1'b1;
              end else begin
                state_d = S_WAIT;
              end
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd7;
            if (rw_q) begin
              tx_req_d  = 1'b1;
              tx_byte_d = i_tx_data;
              sda_oe_d  = ~i_tx_data[7];
              state_d   = S_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[5:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              rx_data_d  = {shreg_q, sda_sync_q};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_RX;
          end
        end
        S_TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              done_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = S_TX_ACK;
            end else begin
              sda_oe_d = ~tx_byte_q[bit_cnt_q];
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 3'd7;
            if (sda_sync_q) begin
              state_d = S_WAIT;
              busy_d  = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            tx_req_d  = 1'b1;
            tx_byte_d = i_tx_data;
            sda_oe_d  = ~i_tx_data[7];
            bit_cnt_d = 3'd7;
            state_d   = S_TX;
          end
        end
        default: ;  // IDLE and WAIT ignore the bus until START or STOP
      endcase
    end
  end

  // All state in one register bank. The async reset releases SDA immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shreg_q    <= 7'h00;
      tx_byte_q  <= 8'h00;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_byte_q  <= tx_byte_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      stop_q     <= stop_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master drives the bus. Expected events are queued
// by the stimulus, and monitors pop and compare them as the DUT produces them.
module tb_i2c_slave;
  localparam int Q = 10;  // quarter SCL period in clocks (SCL = clk/40)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;   // master SCL level
  logic       sda_m = 1'b1;   // 1 = master releases SDA, 0 = master pulls low
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw, busy, stp;
  wire        scl_bus, sda_bus;

  always #5 clk = ~clk;

  assign scl_bus = scl_m;
  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .i_clk(clk), .i_rst(rst), .io_scl(scl_bus), .io_sda(sda_bus),
    .i_tx_data(tx_data), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_tx_req(tx_req), .o_rw(rw), .o_busy(busy), .o_stop(stp)
  );

  int nchk = 0;
  int nerr = 0;
  int viol = 0;
  logic watch = 1'b0;

  logic [7:0] exp_rx[$];
  logic       exp_tx[$];
  logic       exp_stop[$];
  logic       exp_bus[$];
  logic       obs_bus[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: event with nothing queued", nm);
  endtask

  // Scoreboard monitors, all sampled on the falling clock edge
  always @(negedge clk) begin
    logic [7:0] e8;
    logic       e1, o1;
    if (rx_valid) begin
      if (exp_rx.size() == 0) unexpected("rx_valid");
      else begin e8 = exp_rx.pop_front(); chk("rx_data", rx_data, e8); end
    end
    if (tx_req) begin
      if (exp_tx.size() == 0) unexpected("tx_req");
      else begin e1 = exp_tx.pop_front(); chk("tx_req_rw", rw, e1); end
    end
    if (stp) begin
      if (exp_stop.size() == 0) unexpected("stop");
      else begin e1 = exp_stop.pop_front(); chk("stop_busy", busy, e1); end
    end
    if (obs_bus.size() != 0) begin
      o1 = obs_bus.pop_front();
      if (exp_bus.size() == 0) unexpected("bus_bit");
      else begin e1 = exp_bus.pop_front(); chk("bus_bit", o1, e1); end
    end
    if (watch && sda_m && !sda_bus) viol++;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL pulse: put drv on SDA, raise SCL, sample SDA mid-high, lower SCL
  task automatic bit_cycle(input logic drv, output logic smp);
    sda_m = drv; wq(Q);
    scl_m = 1'b1; wq(Q);
    smp = sda_bus; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  // Write a byte and record the slave's ACK-slot level (0 = ACK)
  task automatic wr_byte(input logic [7:0] b, input logic ack_exp);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    exp_bus.push_back(ack_exp ? 1'b0 : 1'b1);
    bit_cycle(1'b1, s);
    obs_bus.push_back(s);
  endtask

  // Read a byte, checking each bit the slave presents, then give ACK or NACK
  task automatic rd_byte(input logic [7:0] b, input logic m_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      exp_bus.push_back(b[i]);
      bit_cycle(1'b1, s);
      obs_bus.push_back(s);
    end
    bit_cycle(m_ack ? 1'b0 : 1'b1, s);
  endtask

  initial begin
    logic s;
    // Reset state
    wq(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop", stp, 0);
    chk("rst_sda", sda_bus, 1);
    rst = 1'b0;
    wq(Q);

    // Write 0x3C to 0x50
    m_start();
    wr_byte(8'hA0, 1'b1);
    chk("wr_busy_after_addr", busy, 1);
    chk("wr_rw", rw, 0);
    exp_rx.push_back(8'h3C);
    wr_byte(8'h3C, 1'b1);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);
    chk("wr_busy_after_stop", busy, 0);

    // Read two bytes: ACK then NACK
    tx_data = 8'h96;
    exp_tx.push_back(1'b1);
    m_start();
    wr_byte(8'hA1, 1'b1);
    tx_data = 8'h5A;
    chk("rd_busy", busy, 1);
    exp_tx.push_back(1'b1);
    rd_byte(8'h96, 1'b1);
    rd_byte(8'h5A, 1'b0);
    chk("rd_sda_released", sda_bus, 1);
    chk("rd_busy_after_nack", busy, 0);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);

    // Wrong address: no ACK, no drive, no data
    m_start();
    watch = 1'b1;
    wr_byte(8'hA2, 1'b0);
    wr_byte(8'h55, 1'b0);
    chk("bad_addr_busy", busy, 0);
    exp_stop.push_back(1'b0);
    m_stop();
    watch = 1'b0;
    wq(Q);

    // Write 0x11, repeated START, then read
    m_start();
    wr_byte(8'hA0, 1'b1);
    exp_rx.push_back(8'h11);
    wr_byte(8'h11, 1'b1);
    tx_data = 8'hC3;
    m_start();
    chk("rs_rw_before", rw, 0);
    exp_tx.push_back(1'b1);
    wr_byte(8'hA1, 1'b1);
    chk("rs_rw_after", rw, 1);
    rd_byte(8'hC3, 1'b0);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);

    // Reset during the 4th data bit, then a clean write of 0x77
    m_start();
    wr_byte(8'hA0, 1'b1);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(3);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_sda", sda_bus, 1);
    chk("rst_mid_busy", busy, 0);
    wq(2);
    rst = 1'b0;
    wq(Q);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);
    m_start();
    wr_byte(8'hA0, 1'b1);
    exp_rx.push_back(8'h77);
    wr_byte(8'h77, 1'b1);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);

    // STOP after three data bits
    m_start();
    wr_byte(8'hA0, 1'b1);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    bit_cycle(1'b1, s);
    exp_stop.push_back(1'b0);
    m_stop();
    wq(Q);
    chk("mid_stop_busy", busy, 0);
    chk("mid_stop_sda", sda_bus, 1);

    // Drain and confirm every queued expectation was met
    wq(4 * Q);
    chk("rx_left", exp_rx.size(), 0);
    chk("tx_left", exp_tx.size(), 0);
    chk("stop_left", exp_stop.size(), 0);
    chk("bus_left", exp_bus.size(), 0);
    chk("no_drive_viol", viol, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Time bound so the run always ends
  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", nchk);
    $fatal(1);
  end

endmodule
